vend_dispense_sequencer: RTL and testbench

//   Post-sale sequencer between the vending FSM and the physical mechanism. On a

---
 rtl/vend_dispense_sequencer.sv | 148 ++++++++++++++
 tb/tb_vend_dispense_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_dispense_sequencer.sv
// Post-sale dispense sequencer: drives one spiral motor until the item drops,
// then pays change coin by coin through the hopper, with timeouts on both phases.
module vend_dispense_sequencer #(
  parameter int MOTOR_TIMEOUT  = 32,
  parameter int HOPPER_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vend_req,
  input  logic [1:0] vend_item,
  input  logic [2:0] vend_cng,
  input  logic       drop_sns,
  input  logic       hopper_ack,
  input  logic       fault_clr,
  output logic [3:0] motor_en,
  output logic       hopper_pulse,
  output logic       vend_busy,
  output logic       vend_done,
  output logic       vend_fault,
  output logic [1:0] fault_code,
  output logic [2:0] paid_cnt
);

  localparam int TMAX = (MOTOR_TIMEOUT > HOPPER_TIMEOUT) ? MOTOR_TIMEOUT : HOPPER_TIMEOUT;
  localparam int TW   = $clog2(TMAX);

  typedef enum logic [2:0] {
    S_IDLE, S_MOTOR, S_PAYOUT_REQ, S_PAYOUT_WAIT, S_DONE, S_FAULT
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [1:0]      r_item;
  logic [1:0]      w_item_nxt;
  logic [2:0]      r_cng_left;
  logic [2:0]      r_paid_cnt;
  logic [TW-1:0]   r_timer;
  logic [1:0]      r_fault_code;
  logic            w_motor_to;
  logic            w_hopper_to;

  logic [3:0]      r_motor_en,     w_motor_en_nxt;
  logic            r_hopper_pulse, w_hopper_pulse_nxt;
  logic            r_busy,         w_busy_nxt;
  logic            r_done,         w_done_nxt;
  logic            r_fault,        w_fault_nxt;

  assign w_motor_to  = (r_timer == TW'(MOTOR_TIMEOUT - 1));
  assign w_hopper_to = (r_timer == TW'(HOPPER_TIMEOUT - 1));

  // NOTE: state and all registered outputs use non-blocking assignments so every
  // flop samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_motor_en     <= 4'b0000;
      r_hopper_pulse <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_fault        <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_motor_en     <= w_motor_en_nxt;
      r_hopper_pulse <= w_hopper_pulse_nxt;
      r_busy         <= w_busy_nxt;
      r_done         <= w_done_nxt;
      r_fault        <= w_fault_nxt;
    end
  end

  // NOTE: the default assignment at the top keeps this block free of latches.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:        if (vend_req) w_state_nxt = S_MOTOR;
      S_MOTOR: begin
        // A drop in the final timer cycle still counts as a good vend.
        if (drop_sns)        w_state_nxt = (r_cng_left == 3'd0) ? S_DONE : S_PAYOUT_REQ;
        else if (w_motor_to) w_state_nxt = S_FAULT;
      end
      S_PAYOUT_REQ:  w_state_nxt = S_PAYOUT_WAIT;
      S_PAYOUT_WAIT: begin
        if (hopper_ack)       w_state_nxt = (r_cng_left == 3'd1) ? S_DONE : S_PAYOUT_REQ;
        else if (w_hopper_to) w_state_nxt = S_FAULT;
      end
      S_DONE:        w_state_nxt = S_IDLE;
      S_FAULT:       if (fault_clr) w_state_nxt = S_IDLE;
      default:       w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up
  // with the state they describe.
  always_comb begin
    w_item_nxt         = (r_state == S_IDLE && vend_req) ? vend_item : r_item;
    w_motor_en_nxt     = (w_state_nxt == S_MOTOR) ? (4'b0001 << w_item_nxt) : 4'b0000;
    w_hopper_pulse_nxt = (w_state_nxt == S_PAYOUT_REQ);
    w_busy_nxt         = (w_state_nxt != S_IDLE);
    w_done_nxt         = (w_state_nxt == S_DONE);
    w_fault_nxt        = (w_state_nxt == S_FAULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_item       <= 2'd0;
      r_cng_left   <= 3'd0;
      r_paid_cnt   <= 3'd0;
      r_timer      <= '0;
      r_fault_code <= 2'd0;
    end else begin
      r_item <= w_item_nxt;
      unique case (r_state)
        S_IDLE: begin
          if (vend_req) begin
            r_cng_left <= vend_cng;
            r_paid_cnt <= 3'd0;
            r_timer    <= '0;
          end
        end
        S_MOTOR: begin
          r_timer <= r_timer + TW'(1);
          if (w_state_nxt == S_FAULT) r_fault_code <= 2'd1;
        end
        S_PAYOUT_REQ: r_timer <= '0;
        S_PAYOUT_WAIT: begin
          if (hopper_ack) begin
            r_cng_left <= r_cng_left - 3'd1;
            r_paid_cnt <= r_paid_cnt + 3'd1;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
          if (w_state_nxt == S_FAULT) r_fault_code <= 2'd2;
        end
        S_FAULT: if (fault_clr) r_fault_code <= 2'd0;
        default: ;
      endcase
    end
  end

  assign motor_en     = r_motor_en;
  assign hopper_pulse = r_hopper_pulse;
  assign vend_busy    = r_busy;
  assign vend_done    = r_done;
  assign vend_fault   = r_fault;
  assign fault_code   = r_fault_code;
  assign paid_cnt     = r_paid_cnt;

endmodule

// File: tb/tb_vend_dispense_sequencer.sv
// Randomised bench: a driver plays the mechanism, a transaction-level model
// predicts each outcome into a queue, and a monitor checks it on done/fault.
module tb_vend_dispense_sequencer;

  localparam int MT = 32;
  localparam int HT = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       vend_req, drop_sns, hopper_ack, fault_clr;
  logic [1:0] vend_item;
  logic [2:0] vend_cng;
  logic [3:0] motor_en;
  logic       hopper_pulse, vend_busy, vend_done, vend_fault;
  logic [1:0] fault_code;
  logic [2:0] paid_cnt;

  vend_dispense_sequencer #(.MOTOR_TIMEOUT(MT), .HOPPER_TIMEOUT(HT)) dut (
    .clk(clk), .rst(rst), .vend_req(vend_req), .vend_item(vend_item),
    .vend_cng(vend_cng), .drop_sns(drop_sns), .hopper_ack(hopper_ack),
    .fault_clr(fault_clr), .motor_en(motor_en), .hopper_pulse(hopper_pulse),
    .vend_busy(vend_busy), .vend_done(vend_done), .vend_fault(vend_fault),
    .fault_code(fault_code), .paid_cnt(paid_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_fault;
    int code;
    int paid;
    int pulses;
    int mcyc;
    int mask;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Hopper behaviour for the current transaction, read by the responder.
  int tb_k = 0;
  int tb_a = 1;
  bit tb_stray = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // d: MOTOR cycle carrying drop_sns (d > MT means no drop while in MOTOR);
  // k: coins the hopper acknowledges; a: cycles from pulse to ack.
  function automatic exp_t model(input int item, input int cng, input int d,
                                 input int k, input int a);
    exp_t e;
    e.mask = 1 << item;
    e.code = 0; e.paid = 0; e.pulses = 0; e.is_fault = 1'b0;
    if (d > MT) begin
      e.mcyc = MT; e.is_fault = 1'b1; e.code = 1;
    end else begin
      e.mcyc = d;
      if (cng != 0) begin
        e.paid = (a <= HT) ? ((k < cng) ? k : cng) : 0;
        if (e.paid == cng) e.pulses = cng;
        else begin
          e.is_fault = 1'b1; e.code = 2; e.pulses = e.paid + 1;
        end
      end
    end
    return e;
  endfunction

  // Hopper responder: optional stray ack inside PAYOUT_REQ, then a real ack.
  initial begin
    int cnt;
    cnt = 0;
    @(negedge clk);
    forever begin
      if (!vend_busy) cnt = 0;
      if (hopper_pulse && !rst) begin
        if (tb_stray) hopper_ack = 1'b1;
        @(negedge clk);
        hopper_ack = 1'b0;
        if (cnt < tb_k) begin
          repeat (tb_a - 1) @(negedge clk);
          hopper_ack = 1'b1;
          @(negedge clk);
          hopper_ack = 1'b0;
          cnt++;
        end
      end else begin
        @(negedge clk);
      end
    end
  end

  // Monitor: accumulates activity and scores it when done or fault appears.
  initial begin
    int  mcyc, mor, pulses;
    bit  prev_done, prev_fault;
    exp_t e;
    mcyc = 0; mor = 0; pulses = 0; prev_done = 1'b0; prev_fault = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mcyc = 0; mor = 0; pulses = 0; prev_done = 1'b0; prev_fault = 1'b0;
      end else begin
        if (motor_en != 4'b0000) begin
          mcyc++;
          mor |= int'(motor_en);
        end
        if (hopper_pulse) pulses++;
        if (prev_done) check("done_one_cycle", int'(vend_done), 0);
        if ((vend_done && !prev_done) || (vend_fault && !prev_fault)) begin
          if (exp_q.size() == 0) begin
            check("unexpected_completion", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("outcome_fault", int'(vend_fault), int'(e.is_fault));
            check("fault_code",    int'(fault_code), e.code);
            check("paid_cnt",      int'(paid_cnt),   e.paid);
            check("pulse_count",   pulses,           e.pulses);
            check("motor_cycles",  mcyc,             e.mcyc);
            check("motor_mask",    mor,              e.mask);
            check("busy_at_end",   int'(vend_busy),  1);
          end
          mcyc = 0; mor = 0; pulses = 0;
        end
        prev_done  = vend_done;
        prev_fault = vend_fault;
      end
    end
  end

  task automatic check_all_zero(input string name);
    check({name, "_motor_en"}, int'(motor_en), 0);
    check({name, "_pulse"},    int'(hopper_pulse), 0);
    check({name, "_busy"},     int'(vend_busy), 0);
    check({name, "_done"},     int'(vend_done), 0);
    check({name, "_fault"},    int'(vend_fault), 0);
    check({name, "_code"},     int'(fault_code), 0);
    check({name, "_paid"},     int'(paid_cnt), 0);
  endtask

  task automatic run_txn(input int item, input int cng, input int d, input int k,
                         input int a, input bit stray, input bit inj);
    int n;
    tb_k = k; tb_a = a; tb_stray = stray;
    exp_q.push_back(model(item, cng, d, k, a));
    vend_item = 2'(item);
    vend_cng  = 3'(cng);
    vend_req  = 1'b1;
    @(negedge clk);
    vend_req = 1'b0;
    for (int c = 1; c <= d; c++) begin
      if (c == 2 && inj) begin
        vend_req  = 1'b1;
        vend_item = 2'(item) ^ 2'b01;
        vend_cng  = 3'(cng) ^ 3'b101;
      end
      if (c == d) drop_sns = 1'b1;
      @(negedge clk);
      vend_req = 1'b0;
      drop_sns = 1'b0;
    end
    n = 0;
    while (!(vend_done || vend_fault) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("txn_timeout", n, 0);
    if (vend_fault) begin
      vend_req = 1'b1;
      @(negedge clk);
      vend_req = 1'b0;
      repeat (3) @(negedge clk);
      check("fault_held", int'(vend_fault), 1);
      check("fault_motor_off", int'(motor_en), 0);
      fault_clr = 1'b1;
      @(negedge clk);
      fault_clr = 1'b0;
      @(negedge clk);
      check("clr_fault", int'(vend_fault), 0);
      check("clr_busy", int'(vend_busy), 0);
      check("clr_code", int'(fault_code), 0);
    end else begin
      repeat (2) @(negedge clk);
      check("idle_after_done", int'(vend_busy), 0);
    end
  endtask

  task automatic reset_in_payout_wait();
    int n;
    tb_k = 1; tb_a = 1; tb_stray = 1'b0;
    vend_item = 2'd3; vend_cng = 3'd2; vend_req = 1'b1;
    @(negedge clk);
    vend_req = 1'b0;
    drop_sns = 1'b1;
    @(negedge clk);
    drop_sns = 1'b0;
    n = 0;
    while (paid_cnt != 3'd1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rst_setup_paid", int'(paid_cnt), 1);
    repeat (2) @(negedge clk);
    check("rst_setup_busy", int'(vend_busy), 1);
    #2 rst = 1'b1;
    #1 check_all_zero("midrst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    vend_req = 1'b0; vend_item = 2'd0; vend_cng = 3'd0;
    drop_sns = 1'b0; hopper_ack = 1'b0; fault_clr = 1'b0;
    #3 check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_txn(2, 0, 5,      0, 1, 1'b0, 1'b0);
    run_txn(0, 3, 3,      3, 2, 1'b0, 1'b0);
    run_txn(1, 2, MT + 2, 2, 2, 1'b0, 1'b0);
    run_txn(3, 4, 4,      2, 3, 1'b0, 1'b0);
    run_txn(1, 3, 4,      3, 1, 1'b1, 1'b1);
    run_txn(2, 1, MT,     1, HT, 1'b0, 1'b0);
    run_txn(0, 2, 2,      2, HT + 1, 1'b0, 1'b0);
    reset_in_payout_wait();
    run_txn(3, 1, 1,      1, 1, 1'b0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      int item, cng, d, k, a;
      item = int'($urandom_range(0, 3));
      cng  = int'($urandom_range(0, 7));
      d    = int'($urandom_range(1, MT + 2));
      k    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, cng)) : cng;
      a    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, HT + 2))
                                         : int'($urandom_range(1, 4));
      run_txn(item, cng, d, k, a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
